gpio_input_conditioner: RTL and testbench
=========================================

// Module: gpio_input_conditioner
// PURPOSE
//  Front-end conditioning for the 12 panel GPIO lines feeding the control core.
//  - Synchronises each raw line and debounces it.
//  - Emits clean levels and one-cycle press/release pulses.
//  - Reduces simultaneous command presses to a single one-hot command pulse.
//  - Reduces chunk keys [7:0] to a one-hot select qualified by a valid flag.
// PARAMETERS
//  N_IN            12       number of GPIO lines conditioned
//  DEBOUNCE_CYCLES 250000   consecutive stable cycles before a level flips; legal range >= 2
//  ACTIVE_LOW      0        1: raw line inverted before synchroniser (pressed = 0 on pin)
// PORTS
//  i_clk           in   1      system clock
//  i_rst           in   1      reset, asynchronous, active-high
//  i_gpio_raw      in   N_IN   unsynchronised pin levels
//  o_level         out  N_IN   debounced level, 1 = pressed/asserted
//  o_press         out  N_IN   1-cycle pulse on debounced 0->1
//  o_release       out  N_IN   1-cycle pulse on debounced 1->0
//  o_cmd           out  4      one-hot command pulse {STOP,MIX,PLAY,REC} = bits {3,2,1,0}
//  o_chunk_sel     out  8      debounced o_level[7:0] if exactly one bit set, else 0
//  o_chunk_valid   out  1      1 when o_chunk_sel is non-zero
// BEHAVIOUR
//  Reset: every flop clears and every output is 0. This includes synchroniser
//   stages, counters and levels.
//  Polarity: p = ACTIVE_LOW ? ~i_gpio_raw : i_gpio_raw. Reset fill of the
//   synchroniser is 0 post-inversion.
//  Synchroniser: two flops per line (s1 <= p; s2 <= s1). No other logic is allowed
//   between the two flops.
//  Per-line debounce counter (width $clog2(DEBOUNCE_CYCLES)):
//   - s2 == level: cnt <= 0.
//   - s2 != level and cnt == DEBOUNCE_CYCLES-1: level <= s2; cnt <= 0.
//   - Otherwise: cnt <= cnt + 1.
//   - Any glitch back to level before the terminal count restarts the count from 0.
//  Latency: a raw edge held stable at cycle 0 changes o_level at clock edge
//   2 + DEBOUNCE_CYCLES.
//  Pulses: o_press and o_release are registered and high exactly in the first cycle
//   of the new o_level value. They are never high together on one line. A line
//   produces at most one press per debounced rise.
//  Command lines: GPIO 11=REC, 10=PLAY, 9=MIX, 8=STOP.
//   - o_cmd is registered from the same-edge press pulses (one cycle after o_press).
//   - Priority is STOP > MIX > PLAY > REC. Lower-priority simultaneous presses are
//     dropped, not queued.
//   - o_cmd has at most one bit set and is 0 in all other cycles.
//  Chunk select: o_chunk_sel and o_chunk_valid are registered from o_level[7:0],
//   one cycle after o_level.
//   - Zero bits or 2+ bits held: 0 / 0.
//   - A key's release returns the select to 0 one cycle after its o_level falls.
//  Reset mid-operation:
//   - Pulses in flight are lost.
//   - A line still held after reset deasserts re-qualifies from level 0.
//   - It yields o_press at edge 2 + DEBOUNCE_CYCLES after the first post-reset edge.
//   - This is intentional: downstream treats it as a fresh press.
//  Lines 12..N_IN-1, if any: level and pulses only, with no command mapping.
// STRUCTURE
//  - Shared package control_pkg holds:
//    - GPIO index constants GPIO_REC=11, GPIO_PLAY=10, GPIO_MIX=9, GPIO_STOP=8
//      and GPIO_CHUNK_LSB=0.
//    - Command one-hot constants CMD_REC/CMD_PLAY/CMD_MIX/CMD_STOP.
//    - N_CHUNK=8.
//  - Sub-module debounce_channel: one line's synchroniser, counter, level and
//    press/release. Instantiated N_IN times with a generate loop.
//  - The top level holds the priority encoder for o_cmd and the one-hot check
//    for o_chunk_sel.
// TESTING (bench uses DEBOUNCE_CYCLES=4, ACTIVE_LOW=0)
//  1 Clean press: raise i_gpio_raw[11] at cycle 0 and hold.
//    -> o_level[11] and o_press[11] rise at edge 6.
//    -> o_press[11] lasts 1 cycle; o_cmd=4'b0001 at edge 7 for 1 cycle.
//  2 Bounce: toggle bit 10 high 2 / low 1 / high 2 cycles, then hold.
//    -> no o_press until 4 stable cycles after the last rise.
//    -> exactly one press, then o_cmd=4'b0010.
//  3 Simultaneous: raise bits 8, 9 and 11 on the same cycle.
//    -> o_cmd=4'b1000 only (STOP wins).
//    -> o_press shows 0x0B00 for the one cycle.
//  4 Chunks: hold bit 2 -> o_chunk_sel=8'h04, valid=1. Add bit 5
//    -> after debounce, o_chunk_sel=0 and valid=0. Release bit 2
//    -> o_chunk_sel=8'h20.
//  5 Release: drop bit 2 after it has been qualified.
//    -> o_release[2] is a 1-cycle pulse at edge 6 after the drop.
//    -> o_cmd is unaffected.
//  6 Reset mid-count: assert i_rst at count 2 while bit 9 is held.
//    -> all outputs 0 immediately.
//    -> after deassert, o_press[9] at edge 6 and o_cmd=4'b0100.

Source files
------------

// File: rtl/control_pkg.sv
// ----------------------------------------------------------------------------
// control_pkg
// Shared constants for the panel GPIO front end and the control core.
//   GPIO_*        : panel line indices of the command keys and the chunk bank
//   CMD_*         : one-hot encodings of o_cmd ({STOP,MIX,PLAY,REC} = {3,2,1,0})
//   N_CHUNK       : number of chunk-select keys
//   is_onehot_chunk : true when exactly one chunk key bit is set
// ----------------------------------------------------------------------------
package control_pkg;

    localparam int GPIO_REC       = 11;
    localparam int GPIO_PLAY      = 10;
    localparam int GPIO_MIX       = 9;
    localparam int GPIO_STOP      = 8;
    localparam int GPIO_CHUNK_LSB = 0;

    localparam int N_CHUNK = 8;
    localparam int CMD_W   = 4;

    localparam logic [CMD_W-1:0] CMD_REC  = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_PLAY = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_MIX  = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_STOP = 4'b1000;

    // Clearing the lowest set bit leaves zero only for a single-bit value.
    function automatic logic is_onehot_chunk(input logic [N_CHUNK-1:0] v);
        return (v != '0) && ((v & (v - N_CHUNK'(1))) == '0);
    endfunction

endpackage

// File: rtl/gpio_input_conditioner_if.sv
// ----------------------------------------------------------------------------
// gpio_input_conditioner_if
// Bundles the raw panel lines and every conditioned output of the front end.
//   i_gpio_raw    : unsynchronised pin levels (driven by the board side)
//   o_level       : debounced levels, 1 = pressed
//   o_press       : one-cycle pulse on debounced rise
//   o_release     : one-cycle pulse on debounced fall
//   o_cmd         : one-hot command pulse
//   o_chunk_sel   : one-hot chunk key, 0 when none or several are held
//   o_chunk_valid : qualifier for o_chunk_sel; there is no ready, the
//                   consumer simply samples o_chunk_sel while it is 1
// master = the side that drives the pins, slave = the conditioner.
// ----------------------------------------------------------------------------
interface gpio_input_conditioner_if
    import control_pkg::*;
#(
    parameter int N_IN = 12
);
    logic [N_IN-1:0]    i_gpio_raw;
    logic [N_IN-1:0]    o_level;
    logic [N_IN-1:0]    o_press;
    logic [N_IN-1:0]    o_release;
    logic [CMD_W-1:0]   o_cmd;
    logic [N_CHUNK-1:0] o_chunk_sel;
    logic               o_chunk_valid;

    modport master (
        output i_gpio_raw,
        input  o_level, o_press, o_release, o_cmd, o_chunk_sel, o_chunk_valid
    );

    modport slave (
        input  i_gpio_raw,
        output o_level, o_press, o_release, o_cmd, o_chunk_sel, o_chunk_valid
    );
endinterface

// File: rtl/debounce_channel.sv
// ----------------------------------------------------------------------------
// debounce_channel
// One GPIO line: polarity fix, two-flop synchroniser, stability counter,
// debounced level and registered press/release pulses.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_raw        : unsynchronised pin
//   o_level      : debounced level
//   o_press      : high in the first cycle of a new 1 level
//   o_release    : high in the first cycle of a new 0 level
// ----------------------------------------------------------------------------
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release
);
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             pol_w;
    logic             s1_q, s2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    assign pol_w = ACTIVE_LOW ? ~i_raw : i_raw;

    // Plain two-flop synchroniser, nothing between the stages.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= pol_w;
            s2_q <= s1_q;
        end
    end

    // The count only runs while the synchronised input disagrees with the
    // level; any agreement restarts it, so only an unbroken run flips.
    always_comb begin
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (s2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_TERM) begin
            level_d   = s2_q;
            cnt_d     = '0;
            press_d   = s2_q;
            release_d = ~s2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = release_q;

endmodule

// File: rtl/gpio_input_conditioner.sv
// ----------------------------------------------------------------------------
// gpio_input_conditioner
// Conditions the panel GPIO lines: one debounce_channel per line, then a
// priority encoder turning command presses into a single one-hot o_cmd
// pulse, and a one-hot check turning the chunk keys into o_chunk_sel.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus (slave)  : i_gpio_raw in; o_level, o_press, o_release, o_cmd,
//                  o_chunk_sel, o_chunk_valid out
// N_IN must match the N_IN of the connected interface instance.
// ----------------------------------------------------------------------------
module gpio_input_conditioner
    import control_pkg::*;
#(
    parameter int N_IN            = 12,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    gpio_input_conditioner_if.slave bus
);
    logic [N_IN-1:0]    level_w, press_w, release_w;
    logic [N_CHUNK-1:0] chunk_w;
    logic [CMD_W-1:0]   cmd_q, cmd_d;
    logic [N_CHUNK-1:0] chunk_sel_q, chunk_sel_d;
    logic               chunk_valid_q, chunk_valid_d;

    for (genvar g = 0; g < N_IN; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_raw     (bus.i_gpio_raw[g]),
            .o_level   (level_w[g]),
            .o_press   (press_w[g]),
            .o_release (release_w[g])
        );
    end

    // STOP > MIX > PLAY > REC; losers of a simultaneous press are dropped.
    always_comb begin
        cmd_d = '0;
        if (press_w[GPIO_STOP])      cmd_d = CMD_STOP;
        else if (press_w[GPIO_MIX])  cmd_d = CMD_MIX;
        else if (press_w[GPIO_PLAY]) cmd_d = CMD_PLAY;
        else if (press_w[GPIO_REC])  cmd_d = CMD_REC;
    end

    assign chunk_w = level_w[GPIO_CHUNK_LSB +: N_CHUNK];

    always_comb begin
        chunk_valid_d = is_onehot_chunk(chunk_w);
        chunk_sel_d   = chunk_valid_d ? chunk_w : '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cmd_q         <= '0;
            chunk_sel_q   <= '0;
            chunk_valid_q <= 1'b0;
        end else begin
            cmd_q         <= cmd_d;
            chunk_sel_q   <= chunk_sel_d;
            chunk_valid_q <= chunk_valid_d;
        end
    end

    assign bus.o_level       = level_w;
    assign bus.o_press       = press_w;
    assign bus.o_release     = release_w;
    assign bus.o_cmd         = cmd_q;
    assign bus.o_chunk_sel   = chunk_sel_q;
    assign bus.o_chunk_valid = chunk_valid_q;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Bench for gpio_input_conditioner with DEBOUNCE_CYCLES=4, ACTIVE_LOW=0.
// Inputs change 1 time unit after a rising edge; outputs are compared
// against the reference model on every falling edge.
module tb_gpio_input_conditioner;
  localparam int N_IN = 12;
  localparam int D    = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gpio_input_conditioner_if #(.N_IN(N_IN)) bus ();

  gpio_input_conditioner #(
    .N_IN            (N_IN),
    .DEBOUNCE_CYCLES (D),
    .ACTIVE_LOW      (1'b0)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Level of a line flips once the last D synchronised samples all differ
  // from it; the synchronised sample at edge k is the raw value of edge k-2.
  logic [D+1:0]      m_hist [N_IN];
  logic [N_IN-1:0]   m_level, m_press, m_release;
  logic [3:0]        m_cmd;
  logic [7:0]        m_sel;
  logic              m_valid;

  task automatic model_clear();
    for (int i = 0; i < N_IN; i++) m_hist[i] = '0;
    m_level = '0; m_press = '0; m_release = '0;
    m_cmd = '0; m_sel = '0; m_valid = 1'b0;
  endtask

  task automatic model_step(input logic [N_IN-1:0] raw);
    logic [N_IN-1:0] prev_press, prev_level;
    logic [D-1:0]    win;
    prev_press = m_press;
    prev_level = m_level;
    for (int i = 0; i < N_IN; i++) begin
      m_hist[i]    = {m_hist[i][D:0], raw[i]};
      win          = m_hist[i][D+1:2];
      m_press[i]   = 1'b0;
      m_release[i] = 1'b0;
      if (!m_level[i] && win == '1) begin
        m_level[i] = 1'b1; m_press[i] = 1'b1;
      end else if (m_level[i] && win == '0) begin
        m_level[i] = 1'b0; m_release[i] = 1'b1;
      end
    end
    if (prev_press[8])       m_cmd = 4'b1000;
    else if (prev_press[9])  m_cmd = 4'b0100;
    else if (prev_press[10]) m_cmd = 4'b0010;
    else if (prev_press[11]) m_cmd = 4'b0001;
    else                     m_cmd = 4'b0000;
    m_valid = ($countones(prev_level[7:0]) == 1);
    m_sel   = m_valid ? prev_level[7:0] : 8'h00;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_clear();
      else     model_step(bus.i_gpio_raw);
    end
  end

  // ---------------- scoreboard compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      check("outputs_vs_model",
            {15'd0, bus.o_level, bus.o_press, bus.o_release, bus.o_cmd, bus.o_chunk_sel, bus.o_chunk_valid},
            {15'd0, m_level, m_press, m_release, m_cmd, m_sel, m_valid});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_gpio_raw = '0;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int n_press, press_edge, n_cmd;
    logic [4:0] pat;
    bus.i_gpio_raw = '0;
    step(3);
    check("reset_level", 64'(bus.o_level), 64'h0);
    check("reset_cmd_chunk", {55'd0, bus.o_cmd, bus.o_chunk_sel[3:0], bus.o_chunk_valid}, 64'h0);
    rst = 1'b0;
    step(1);

    // 1: clean press on REC
    bus.i_gpio_raw[11] = 1'b1;
    step(5);
    check("t1_no_press_edge5", 64'(bus.o_press[11]), 64'h0);
    step(1);
    check("t1_level_edge6", 64'(bus.o_level[11]), 64'h1);
    check("t1_press_edge6", 64'(bus.o_press[11]), 64'h1);
    step(1);
    check("t1_press_gone_edge7", 64'(bus.o_press[11]), 64'h0);
    check("t1_cmd_edge7", 64'(bus.o_cmd), 64'h1);
    step(1);
    check("t1_cmd_gone_edge8", 64'(bus.o_cmd), 64'h0);

    // 2: bounce on PLAY: high 2 / low 1 / high 2 then hold
    do_reset();
    pat = 5'b11011;
    n_press = 0; press_edge = -1; n_cmd = 0;
    for (int c = 0; c < 20; c++) begin
      bus.i_gpio_raw[10] = (c < 5) ? pat[c] : 1'b1;
      step(1);
      if (bus.o_press[10]) begin n_press++; press_edge = c + 1; end
      if (bus.o_cmd == 4'b0010) n_cmd++;
    end
    check("t2_press_count", 64'(n_press), 64'd1);
    check("t2_press_edge", 64'(press_edge), 64'd9);
    check("t2_cmd_play_count", 64'(n_cmd), 64'd1);

    // 3: simultaneous STOP, MIX, REC
    do_reset();
    bus.i_gpio_raw = 12'h0B00;
    step(6);
    check("t3_press_vec", 64'(bus.o_press), 64'h0B00);
    step(1);
    check("t3_cmd_stop", 64'(bus.o_cmd), 64'h8);
    check("t3_press_cleared", 64'(bus.o_press), 64'h0);
    step(1);
    check("t3_cmd_gone", 64'(bus.o_cmd), 64'h0);

    // 4 + 5: chunk select and release
    do_reset();
    bus.i_gpio_raw[2] = 1'b1;
    step(7);
    check("t4_sel_key2", {55'd0, bus.o_chunk_sel, bus.o_chunk_valid}, {55'd0, 8'h04, 1'b1});
    bus.i_gpio_raw[5] = 1'b1;
    step(6);
    check("t4_level_two_keys", 64'(bus.o_level[7:0]), 64'h24);
    step(1);
    check("t4_sel_two_keys", {55'd0, bus.o_chunk_sel, bus.o_chunk_valid}, 64'h0);
    bus.i_gpio_raw[2] = 1'b0;
    step(6);
    check("t5_release2_pulse", 64'(bus.o_release[2]), 64'h1);
    check("t5_cmd_untouched", 64'(bus.o_cmd), 64'h0);
    step(1);
    check("t5_release2_one_cycle", 64'(bus.o_release[2]), 64'h0);
    check("t4_sel_key5", {55'd0, bus.o_chunk_sel, bus.o_chunk_valid}, {55'd0, 8'h20, 1'b1});

    // 6: reset mid-count while MIX held (key 5 still qualified)
    bus.i_gpio_raw[9] = 1'b1;
    step(4);
    rst = 1'b1;
    #1;
    check("t6_reset_outputs",
          {15'd0, bus.o_level, bus.o_press, bus.o_release, bus.o_cmd, bus.o_chunk_sel, bus.o_chunk_valid}, 64'h0);
    step(1);
    rst = 1'b0;
    step(5);
    check("t6_no_press_edge5", 64'(bus.o_press[9]), 64'h0);
    step(1);
    check("t6_press_edge6", 64'(bus.o_press[9]), 64'h1);
    step(1);
    check("t6_cmd_mix", 64'(bus.o_cmd), 64'h4);

    // random phase
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N_IN; i++)
        if ($urandom_range(0, 7) == 0) bus.i_gpio_raw[i] = ~bus.i_gpio_raw[i];
      if ($urandom_range(0, 19) == 0) bus.i_gpio_raw[11:8] = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 399) == 0);
      step(1);
    end
    rst = 1'b0;
    step(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
